// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, data width, divisor helper
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Floor division: clocks per oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - oversample tick divider with synchronous clear
module uart_rx_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // A clear realigns the phase, so suppress any tick coinciding with it.
  assign tick = !clr && (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8N1; define UART_RX_PARITY_EN for 8E1
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_line,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic              rx_meta;
  logic              rx_s;
  logic              rx_q;
  logic              tick;
  logic              start_edge;
  logic              parity_ok;
  uart_state_t       state;
  logic [TW-1:0]     tick_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  // Requires a seen 1 before the 0, so a held-low break cannot retrigger.
  assign start_edge = (state == IDLE) && rx_q && !rx_s;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_edge),
    .tick (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign parity_ok = ~(^shift ^ par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              shift[bit_idx] <= rx_s;
              tick_cnt       <= '0;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              par_bit  <= rx_s;
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
              if (rx_s && parity_ok) begin
                data_out   <= shift;
                data_valid <= 1'b1;
              end else begin
                frame_err  <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
